// File: rtl/acc16_pkg.sv
// acc16_pkg: shared types and constants for the acc16 accumulator slice.
package acc16_pkg;
  typedef enum logic [0:0] {ACC, DONE} state_t;
  localparam int DW = 16;
  localparam logic [DW-1:0] SAT_VAL = 16'hFFFF;
endpackage

// File: rtl/cla16.sv
// cla16: 16-bit carry-lookahead adder, four 4-bit groups with a second lookahead level.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [16:0] sum
);
  logic [15:0] g, p;
  logic [16:0] c;
  logic [3:0] bg, bp;
  logic [4:0] bc;
  assign g = a & b;
  assign p = a ^ b;
  for (genvar i = 0; i < 4; i++) begin : grp
    localparam int B = 4 * i;
    assign c[B]   = bc[i];
    assign c[B+1] = g[B] | (p[B] & bc[i]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (&p[B+:2] & bc[i]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (&p[B+1+:2] & g[B]) | (&p[B+:3] & bc[i]);
    assign bg[i]  = g[B+3] | (p[B+3] & g[B+2]) | (&p[B+2+:2] & g[B+1]) | (&p[B+1+:3] & g[B]);
    assign bp[i]  = &p[B+:4];
  end
  assign bc[0] = cin;
  assign bc[1] = bg[0] | (bp[0] & cin);
  assign bc[2] = bg[1] | (bp[1] & bg[0]) | (&bp[1:0] & cin);
  assign bc[3] = bg[2] | (bp[2] & bg[1]) | (&bp[2:1] & bg[0]) | (&bp[2:0] & cin);
  assign bc[4] = bg[3] | (bp[3] & bg[2]) | (&bp[3:2] & bg[1]) | (&bp[3:1] & bg[0]) | (&bp & cin);
  assign c[16] = bc[4];
  assign sum = {c[16], p ^ c[15:0]};
endmodule

// File: rtl/acc16_ctrl.sv
// acc16_ctrl: sums NSAMP 16-bit operands per result with valid/ready on both sides.
// Define ACC16_SAT_EN to saturate the sum at 16'hFFFF instead of wrapping.
module acc16_ctrl
  import acc16_pkg::*;
#(
  parameter int NSAMP = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_ovf
);
  localparam int CW = $clog2(NSAMP + 1);
  localparam logic [CW-1:0] LAST = CW'(NSAMP - 1);
  state_t state;
  logic [DW-1:0] acc, acc_nxt;
  logic [CW-1:0] cnt;
  logic ovf;
  logic [DW:0] sum;
  cla16 u_add (.a(acc), .b(in_data), .cin(1'b0), .sum(sum));
`ifdef ACC16_SAT_EN
  assign acc_nxt = sum[DW] ? SAT_VAL : sum[DW-1:0];
`else
  assign acc_nxt = sum[DW-1:0];
`endif
  assign in_ready  = rst_n && state == ACC && !clear;
  assign out_valid = state == DONE;
  assign out_data  = acc;
  assign out_ovf   = ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear || (out_valid && out_ready)) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (in_valid && in_ready) begin
      acc   <= acc_nxt;
      ovf   <= ovf | sum[DW];
      cnt   <= cnt + CW'(1);
      state <= cnt == LAST ? DONE : ACC;
    end
  end
endmodule

// File: tb/tb_acc16_ctrl.sv
// tb_acc16_ctrl: random and directed checks of acc16_ctrl (NSAMP=4 and NSAMP=16) against a sum-of-operands model.
module tb_acc16_ctrl;
  logic clk, rst_n;
  logic clr[2], iv[2], rdy[2], ov[2], ordy[2], oovf[2];
  logic [15:0] din[2], dout[2];
  int q0[$], q1[$];
  int n_cmp, n_err, n_out1;

  acc16_ctrl #(.NSAMP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clr[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
    .in_data(din[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(dout[0]), .out_ovf(oovf[0])
  );
  acc16_ctrl #(.NSAMP(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .clear(clr[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
    .in_data(din[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(dout[1]), .out_ovf(oovf[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input int tot);
`ifdef ACC16_SAT_EN
    return tot >= 65536 ? 16'hFFFF : tot[15:0];
`else
    return tot[15:0];
`endif
  endfunction

  // Result is the plain integer sum of the accepted group; any carry-out means the total reached 2^16.
  task automatic check_dut(input int d);
    int qq[$];
    int ns, tot;
    bit pend;
    qq = d ? q1 : q0;
    ns = d ? 16 : 4;
    pend = qq.size() == ns;
    tot = 0;
    foreach (qq[k]) tot += qq[k];
    chk($sformatf("in_ready%0d", d), 32'(rdy[d]), 32'(!pend && !clr[d]));
    chk($sformatf("out_valid%0d", d), 32'(ov[d]), 32'(pend));
    if (pend) begin
      chk($sformatf("out_data%0d", d), 32'(dout[d]), 32'(exp_data(tot)));
      chk($sformatf("out_ovf%0d", d), 32'(oovf[d]), 32'(tot >= 65536));
      if (d == 1 && ordy[d] && !clr[d]) n_out1++;
    end
    if (clr[d] || (pend && ordy[d])) qq.delete();
    else if (iv[d] && !pend) qq.push_back(int'(din[d]));
    if (d == 1) q1 = qq; else q0 = qq;
  endtask

  task automatic step();
    #1;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
  endtask

  task automatic feed(input logic [15:0] v);
    iv[0] = 1'b1;
    din[0] = v;
    step();
    iv[0] = 1'b0;
  endtask

  task automatic feed4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] e);
    feed(a); feed(b); feed(c); feed(e);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b1;
    n_cmp = 0; n_err = 0; n_out1 = 0;
    for (int d = 0; d < 2; d++) begin
      clr[d] = 1'b0; iv[d] = 1'b0; ordy[d] = 1'b0; din[d] = '0;
    end
    #2 rst_n = 1'b0;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 32'(rdy[d]), 0);
      chk("rst_out_valid", 32'(ov[d]), 0);
      chk("rst_out_data", 32'(dout[d]), 0);
      chk("rst_out_ovf", 32'(oovf[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ordy[0] = 1'b1;
    step();
    feed4(16'd1, 16'd2, 16'd3, 16'd4);
    chk("sum10", 32'(dout[0]), 32'd10);
    step();
    step();
    ordy[0] = 1'b0;
    feed4(16'hFFFF, 16'd2, 16'd0, 16'd0);
    step();
`ifdef ACC16_SAT_EN
    chk("wrap_data", 32'(dout[0]), 32'hFFFF);
`else
    chk("wrap_data", 32'(dout[0]), 32'h0001);
`endif
    ordy[0] = 1'b1;
    step();
    ordy[0] = 1'b0;
    feed4(16'd1, 16'd2, 16'd3, 16'd4);
    iv[0] = 1'b1; din[0] = 16'd7;
    repeat (5) step();
    ordy[0] = 1'b1;
    step();
    ordy[0] = 1'b0;
    step();
    iv[0] = 1'b0;
    feed(16'd1); feed(16'd1); feed(16'd1);
    chk("refill_sum", 32'(dout[0]), 32'd10);
    ordy[0] = 1'b1;
    step();
    feed(16'd5); feed(16'd6);
    clr[0] = 1'b1; iv[0] = 1'b1; din[0] = 16'd100;
    step();
    clr[0] = 1'b0; iv[0] = 1'b0;
    ordy[0] = 1'b0;
    feed4(16'd1, 16'd1, 16'd1, 16'd1);
    chk("after_clear", 32'(dout[0]), 32'd4);
    ordy[0] = 1'b1;
    step();
    ordy[0] = 1'b0;
    feed4(16'd1, 16'd2, 16'd3, 16'd4);
    step();
    ordy[0] = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ov[0]), 0);
    chk("async_rst_ready", 32'(rdy[0]), 0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    feed4(16'd9, 16'd9, 16'd9, 16'd9);
    chk("after_rst", 32'(dout[0]), 32'd36);
    step();
    for (int c = 0; c < 600; c++) begin
      iv[0] = 1'($urandom_range(0, 1));
      din[0] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
      ordy[0] = 1'($urandom_range(0, 1));
      clr[0] = $urandom_range(0, 31) == 0;
      iv[1] = $urandom_range(0, 3) != 0;
      din[1] = 16'h1000;
      ordy[1] = $urandom_range(0, 2) != 0;
      step();
    end
    chk("grp16_results", 32'(n_out1 > 2), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/acc16_ctrl.md
ACC16_CTRL -- requirements
Module: acc16_ctrl

Interface
REQ-001 Parameter NSAMP, default 4, number of 16-bit words summed per result; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 clear  input  1  synchronous abort: empties the accumulator, count and any pending result.
REQ-005 in_valid  input  1  in_data holds a valid operand.
REQ-006 in_ready  output  1  block accepts an operand this cycle.
REQ-007 in_data  input  16  unsigned operand.
REQ-008 out_valid  output  1  out_data/out_ovf hold a finished result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_data  output  16  unsigned sum of NSAMP operands.
REQ-011 out_ovf  output  1  the 16-bit sum carried out at least once in this group.

Function
REQ-012 The block SHALL have two states: ACC (collecting operands) and DONE (holding a result).
REQ-013 in_ready SHALL be 1 exactly when the state is ACC and clear is 0.
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both 1; when in_valid is 0, acc, cnt and ovf SHALL hold.
REQ-015 On each input transfer, acc SHALL load the low 16 bits of acc+in_data, ovf SHALL OR in bit 16, and cnt SHALL increment.
REQ-016 On the transfer that makes cnt equal NSAMP, the state SHALL move to DONE and out_valid SHALL be 1 from the next cycle; latency from last operand to result is 1 cycle.
REQ-017 In DONE, out_data = acc and out_ovf = ovf, and both SHALL stay stable until the output transfer (out_valid and out_ready both 1).
REQ-018 On an output transfer, acc, cnt and ovf SHALL clear and the state SHALL return to ACC; in_ready SHALL stay 0 during the transfer cycle (no same-cycle refill).
REQ-019 In DONE, in_valid SHALL be ignored and no operand is lost, because in_ready is 0.
REQ-020 clear SHALL take priority over both transfers: next cycle acc=0, cnt=0, ovf=0, state=ACC and out_valid=0; a pending result is discarded.
REQ-021 The sum width SHALL be 17 bits; bit 16 SHALL only feed ovf (or saturation, REQ-025).
REQ-022 The cnt width SHALL be $clog2(NSAMP+1) bits; cnt SHALL never exceed NSAMP.

Reset
REQ-023 While rst_n is 0: state=ACC, acc=0, cnt=0, ovf=0, out_valid=0, out_data=0, out_ovf=0 and in_ready=0; the first cycle after release SHALL give in_ready=1.
REQ-024 Reset asserted in DONE or mid-group SHALL discard all partial and pending data, with no output transfer.

Configuration
REQ-025 With macro ACC16_SAT_EN defined, a carry-out SHALL load acc with 16'hFFFF, and acc SHALL stay 16'hFFFF for the rest of the group; ovf is still set.
REQ-026 Without ACC16_SAT_EN, acc SHALL wrap modulo 2^16 and only ovf records the carry.

Structure
REQ-027 The shared package acc16_pkg SHALL hold the state enum type (ACC, DONE), the data width constant 16 and the saturation value 16'hFFFF.
REQ-028 The 16+16 addition SHALL use one instance of the team's existing 16-bit carry-lookahead adder cla16, with its sum[16] taken as the carry-out; no other sub-module.

Verification
REQ-029 NSAMP=4, in_data 1,2,3,4 back-to-back, out_ready=1 -> out_valid one cycle after 4th transfer, out_data=10, out_ovf=0, then in_ready=1 one cycle later.
REQ-030 NSAMP=4, inputs 16'hFFFF,2,0,0 -> default build out_data=16'h0001, out_ovf=1; ACC16_SAT_EN build out_data=16'hFFFF, out_ovf=1.
REQ-031 Result pending with out_ready=0 for 5 cycles and in_valid=1 with in_data=7 -> in_ready=0, out_data stable at 10; 7 accepted only after the output transfer, in the new group.
REQ-032 clear pulsed after 2 of 4 operands (5,6) -> next group 1,1,1,1 gives out_data=4, out_ovf=0.
REQ-033 rst_n low in DONE -> out_valid=0 asynchronously, no output transfer; after release, group 9,9,9,9 gives out_data=36.
REQ-034 Random in_valid/out_ready gaps, NSAMP=16, operands 16'h1000 -> out_data=0, out_ovf=1 (default build), and the scoreboard matches a reference sum for every result.
